// File: rtl/cpu_jtag_ocimem_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_jtag_ocimem_sequencer
//
// Purpose:
//   Sequences JTAG debug accesses into a small debug RAM that is shared with
//   the CPU. JTAG strobes load an address, request a write, or request a read.
//   The CPU normally owns the RAM. A pending JTAG access waits for a cycle with
//   cpu_req low. If the CPU keeps requesting, a 2-bit starve counter lets JTAG
//   take the RAM after three refused cycles.
//
// Ports:
//   clk                     in   sole clock, rising edge
//   reset_n                 in   asynchronous active-low reset
//   jdo[37:0]               in   JTAG data word; addr = jdo[17:10], wdata = jdo[34:3]
//   take_action_ocimem_a    in   strobe: load address (accepted in any state)
//   take_action_ocimem_b    in   strobe: write command
//   take_no_action_ocimem_a in   strobe: read command
//   cpu_req                 in   CPU wants the RAM
//   cpu_gnt                 out  CPU owns the RAM this cycle
//   mem_cs / mem_we         out  JTAG-side RAM chip-select / write enable
//   mem_addr[7:0]           out  RAM word address
//   mem_wdata[31:0]         out  RAM write data
//   mem_rdata[31:0]         in   RAM read data, valid the cycle after mem_cs
//   MonDReg[31:0]           out  captured read data
//   monitor_ready           out  last command complete
//   monitor_error           out  a read/write strobe was dropped
//
// Configuration:
//   OCIMEM_AUTOINC_EN  when defined, the address increments by one at the end
//                      of every RAM access. An address-load strobe in the same
//                      cycle takes priority.
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module cpu_jtag_ocimem_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  input  logic        cpu_req,
  output logic        cpu_gnt,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_GNT = 2'd1,
    S_ACCESS   = 2'd2,
    S_CAPTURE  = 2'd3
  } state_t;

  state_t      state_q,  state_d;
  logic [7:0]  addr_q,   addr_d;
  logic [31:0] wdata_q,  wdata_d;
  logic        op_wr_q,  op_wr_d;
  logic [1:0]  starve_q, starve_d;
  logic [31:0] mon_q,    mon_d;
  logic        ready_q,  ready_d;
  logic        error_q,  error_d;
  logic        cs_q,     cs_d;
  logic        we_q,     we_d;
  logic        gnt_q,    gnt_d;

  logic        wr_stb_s;
  logic        rd_stb_s;
  logic [1:0]  starve_inc_s;
  logic        unused_jdo_s;

  assign wr_stb_s     = take_action_ocimem_b;
  assign rd_stb_s     = take_no_action_ocimem_a;
  assign starve_inc_s = starve_q + 2'd1;

  // jdo[37:35] and jdo[2:0] carry no field for this block.
  assign unused_jdo_s = ^{jdo[37:35], jdo[2:0]};

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    op_wr_d  = op_wr_q;
    starve_d = starve_q;
    mon_d    = mon_q;
    ready_d  = ready_q;
    error_d  = error_q;
    cs_d     = 1'b0;
    we_d     = 1'b0;
    gnt_d    = 1'b1;

    // A read/write strobe is accepted only in IDLE. In any other state it is dropped and flagged.
    if ((state_q != S_IDLE) && (wr_stb_s || rd_stb_s)) begin
      error_d = 1'b1;
    end else begin
      error_d = error_q;
    end

    case (state_q)
      S_IDLE: begin
        if (wr_stb_s) begin
          // Write wins a tie with read. The losing read is reported as dropped.
          wdata_d  = jdo[34:3];
          op_wr_d  = 1'b1;
          starve_d = 2'd0;
          ready_d  = 1'b0;
          error_d  = rd_stb_s;
          state_d  = S_WAIT_GNT;
        end else if (rd_stb_s) begin
          op_wr_d  = 1'b0;
          starve_d = 2'd0;
          ready_d  = 1'b0;
          error_d  = 1'b0;
          state_d  = S_WAIT_GNT;
        end else begin
          state_d  = S_IDLE;
        end
      end

      S_WAIT_GNT: begin
        if (!cpu_req) begin
          starve_d = 2'd0;
          state_d  = S_ACCESS;
        end else if (starve_inc_s == 2'd3) begin
          // The CPU has refused JTAG three cycles in a row, so JTAG takes the RAM next cycle.
          starve_d = 2'd0;
          state_d  = S_ACCESS;
        end else begin
          starve_d = starve_inc_s;
          state_d  = S_WAIT_GNT;
        end
      end

      S_ACCESS: begin
`ifdef OCIMEM_AUTOINC_EN
        addr_d = addr_q + 8'd1;
`else
        addr_d = addr_q;
`endif
        if (op_wr_q) begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        mon_d   = mem_rdata;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An address load overrides any auto-increment. It also clears a pending
    // ready in the same cycle.
    if (take_action_ocimem_a) begin
      addr_d  = jdo[17:10];
      ready_d = 1'b0;
    end else begin
      addr_d  = addr_d;
    end

    // The outputs are decoded from the next state, so the flops show the current state's values.
    if (state_d == S_ACCESS) begin
      cs_d  = 1'b1;
      we_d  = op_wr_d;
      gnt_d = 1'b0;
    end else if (state_d == S_CAPTURE) begin
      cs_d  = 1'b0;
      we_d  = 1'b0;
      gnt_d = 1'b0;
    end else begin
      cs_d  = 1'b0;
      we_d  = 1'b0;
      gnt_d = 1'b1;
    end
  end

  // State, datapath and output registers with asynchronous reset.
  // A reset during ACCESS or CAPTURE abandons the access, so no read data is captured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      addr_q   <= 8'd0;
      wdata_q  <= 32'd0;
      op_wr_q  <= 1'b0;
      starve_q <= 2'd0;
      mon_q    <= 32'd0;
      ready_q  <= 1'b0;
      error_q  <= 1'b0;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      gnt_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      op_wr_q  <= op_wr_d;
      starve_q <= starve_d;
      mon_q    <= mon_d;
      ready_q  <= ready_d;
      error_q  <= error_d;
      cs_q     <= cs_d;
      we_q     <= we_d;
      gnt_q    <= gnt_d;
    end
  end

  assign cpu_gnt       = gnt_q;
  assign mem_cs        = cs_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign MonDReg       = mon_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule

// File: tb/tb_cpu_jtag_ocimem_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for cpu_jtag_ocimem_sequencer.
//
// The driver issues one input set per clock. A reference model predicts each
// command's RAM access and completion from the command rules. A separate
// monitor pops those predictions whenever the DUT raises mem_cs or a new
// monitor_ready. The bench also contains a synchronous RAM.
// -----------------------------------------------------------------------------
module tb_cpu_jtag_ocimem_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic        cpu_req;
  logic        cpu_gnt;
  logic        mem_cs;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  always #5 clk = ~clk;

  cpu_jtag_ocimem_sequencer dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .cpu_req                 (cpu_req),
    .cpu_gnt                 (cpu_gnt),
    .mem_cs                  (mem_cs),
    .mem_we                  (mem_we),
    .mem_addr                (mem_addr),
    .mem_wdata               (mem_wdata),
    .mem_rdata               (mem_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] pat(input int i);
    return 32'h5A00_0000 ^ (i * 32'h0001_0203) ^ 32'h0000_00C3;
  endfunction

  // Environment RAM: synchronous read, data valid the cycle after mem_cs.
  logic [31:0] ram [256];
  logic        ram_fill;
  always @(posedge clk) begin
    if (ram_fill) begin
      for (int i = 0; i < 256; i++) ram[i] <= pat(i);
    end else if (mem_cs) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0]  a;
    logic        we;
    logic [31:0] d;
  } acc_t;

  acc_t        acc_q[$];
  logic [31:0] done_q[$];
  logic [31:0] mram [256];
  logic [7:0]  m_addr;
  logic        m_err;
  logic [31:0] m_last;
  logic        m_req_hold;
  int          busy;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_addr = 8'd0; m_err = 1'b0; m_last = 32'd0; busy = 0; m_req_hold = 1'b0;
  endtask

  // Drives one cycle of inputs at a negedge, updates the model, and waits for
  // the next negedge. It then compares the error flag.
  task automatic step(input logic ld, input logic wr, input logic rd,
                      input logic [37:0] j, input logic req);
    logic accepted;
    int   w;
    acc_t e;
    accepted = 1'b0;
    jdo = j;
    take_action_ocimem_a    = ld;
    take_action_ocimem_b    = wr;
    take_no_action_ocimem_a = rd;
    cpu_req = (busy > 0) ? m_req_hold : req;
    if (ld) m_addr = j[17:10];
    if (wr || rd) begin
      if (busy > 0) begin
        m_err = 1'b1;
      end else begin
        accepted   = 1'b1;
        m_err      = wr && rd;
        m_req_hold = req;
        // The CPU waits 1 cycle, or 3 cycles if it keeps requesting the RAM.
        w = req ? 3 : 1;
        e.a = m_addr;
        if (wr) begin
          e.we = 1'b1; e.d = j[34:3];
          mram[m_addr] = j[34:3];
          busy = w + 1;
        end else begin
          e.we = 1'b0; e.d = 32'd0;
          m_last = mram[m_addr];
          busy = w + 2;
        end
        acc_q.push_back(e);
        done_q.push_back(m_last);
`ifdef OCIMEM_AUTOINC_EN
        m_addr = m_addr + 8'd1;
`endif
      end
    end
    if (!accepted && busy > 0) busy--;
    @(negedge clk);
    chk("monitor_error", monitor_error, m_err);
  endtask

  task automatic idle(input logic req);
    step(1'b0, 1'b0, 1'b0, 38'd0, req);
  endtask

  // ---------------- monitor ----------------
  logic        rdy_prev = 1'b0;
  acc_t        got_e;
  logic [31:0] exp_mon;
  always @(negedge clk) begin
    if (!reset_n) begin
      rdy_prev = 1'b0;
    end else begin
      if (mem_cs) begin
        if (acc_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL access: unexpected access addr=%0h we=%0b expected none", mem_addr, mem_we);
        end else begin
          got_e = acc_q.pop_front();
          chk("acc_addr", {56'd0, mem_addr}, {56'd0, got_e.a});
          chk("acc_we", {63'd0, mem_we}, {63'd0, got_e.we});
          if (got_e.we) chk("acc_wdata", {32'd0, mem_wdata}, {32'd0, got_e.d});
        end
      end
      if (monitor_ready && !rdy_prev) begin
        if (done_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL ready: unexpected completion MonDReg=%0h expected none", MonDReg);
        end else begin
          exp_mon = done_q.pop_front();
          chk("MonDReg", {32'd0, MonDReg}, {32'd0, exp_mon});
        end
      end
      rdy_prev = monitor_ready;
    end
  end

  // ---------------- stimulus ----------------
  logic [37:0] jw;
  logic [63:0] r;
  int          c;
  logic        ld, wr, rd, rq;
  logic [7:0]  exp_a;
  logic        exp_g [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    cpu_req = 1'b0;
    ram_fill = 1'b1;
    for (int i = 0; i < 256; i++) mram[i] = pat(i);
    model_reset();
    @(posedge clk); @(posedge clk);
    ram_fill = 1'b0;
    @(negedge clk); #2 reset_n = 1'b1;
    @(negedge clk);

    // Reset values
    chk("rst_gnt", cpu_gnt, 1'b1);
    chk("rst_cs", mem_cs, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_ready", monitor_ready, 1'b0);
    chk("rst_error", monitor_error, 1'b0);
    chk("rst_mon", MonDReg, 32'd0);
    chk("rst_addr", mem_addr, 8'd0);
    chk("rst_wdata", mem_wdata, 32'd0);

    // Write 0xDEADBEEF at 0x10 with cpu_req low
    jw = '0; jw[17:10] = 8'h10; step(1'b1, 1'b0, 1'b0, jw, 1'b0);
    jw = '0; jw[34:3] = 32'hDEADBEEF; step(1'b0, 1'b1, 1'b0, jw, 1'b0);
    chk("w_cs_wait", mem_cs, 1'b0);
    idle(1'b0);
    chk("w_cs", mem_cs, 1'b1);
    chk("w_we", mem_we, 1'b1);
    chk("w_addr", mem_addr, 8'h10);
    chk("w_ready_early", monitor_ready, 1'b0);
    idle(1'b0);
    chk("w_ready", monitor_ready, 1'b1);
    chk("w_cs_done", mem_cs, 1'b0);

    // Read back from 0x10
    jw = '0; jw[17:10] = 8'h10; step(1'b1, 1'b0, 1'b0, jw, 1'b0);
    step(1'b0, 1'b0, 1'b1, 38'd0, 1'b0);
    chk("r_ready_clr", monitor_ready, 1'b0);
    idle(1'b0);
    chk("r_cs", mem_cs, 1'b1);
    chk("r_we", mem_we, 1'b0);
    idle(1'b0);
    chk("r_ready_early", monitor_ready, 1'b0);
    idle(1'b0);
    chk("r_mon", MonDReg, 32'hDEADBEEF);
    chk("r_ready", monitor_ready, 1'b1);
`ifdef OCIMEM_AUTOINC_EN
    exp_a = 8'h11;
`else
    exp_a = 8'h10;
`endif
    chk("r_addr_after", mem_addr, exp_a);

    // CPU keeps requesting: three granted cycles, then JTAG takes two cycles
    step(1'b0, 1'b0, 1'b1, 38'd0, 1'b1);
    chk("starve_gnt0", cpu_gnt, exp_g[0]);
    for (int k = 1; k < 6; k++) begin
      idle(1'b1);
      chk("starve_gnt", cpu_gnt, exp_g[k]);
    end

    // Address wrap: write at 0xFF, then a second write
    jw = '0; jw[17:10] = 8'hFF; step(1'b1, 1'b0, 1'b0, jw, 1'b0);
    jw = '0; jw[34:3] = 32'h1234_5678; step(1'b0, 1'b1, 1'b0, jw, 1'b0);
    idle(1'b0); idle(1'b0); idle(1'b0);
    jw = '0; jw[34:3] = 32'hCAFE_F00D; step(1'b0, 1'b1, 1'b0, jw, 1'b0);
    idle(1'b0);
`ifdef OCIMEM_AUTOINC_EN
    exp_a = 8'h00;
`else
    exp_a = 8'hFF;
`endif
    chk("wrap_addr", mem_addr, exp_a);
    idle(1'b0); idle(1'b0);

    // Read strobe during CAPTURE is dropped; write+read together writes only
    jw = '0; jw[17:10] = 8'h20; step(1'b1, 1'b0, 1'b0, jw, 1'b0);
    step(1'b0, 1'b0, 1'b1, 38'd0, 1'b0);
    idle(1'b0); idle(1'b0);
    step(1'b0, 1'b0, 1'b1, 38'd0, 1'b0);
    idle(1'b0);
    jw = '0; jw[34:3] = 32'hA5A5_0F0F; step(1'b0, 1'b1, 1'b1, jw, 1'b0);
    idle(1'b0); idle(1'b0); idle(1'b0);
    step(1'b0, 1'b0, 1'b1, 38'd0, 1'b0);
    idle(1'b0); idle(1'b0); idle(1'b0);

    // Reset asserted during the ACCESS cycle of a read
    jw = '0; jw[17:10] = 8'h05; step(1'b1, 1'b0, 1'b0, jw, 1'b0);
    step(1'b0, 1'b0, 1'b1, 38'd0, 1'b0);
    idle(1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_gnt", cpu_gnt, 1'b1);
    chk("ar_cs", mem_cs, 1'b0);
    chk("ar_we", mem_we, 1'b0);
    chk("ar_ready", monitor_ready, 1'b0);
    chk("ar_error", monitor_error, 1'b0);
    chk("ar_mon", MonDReg, 32'd0);
    chk("ar_addr", mem_addr, 8'd0);
    chk("ar_wdata", mem_wdata, 32'd0);
    void'(done_q.pop_back());
    model_reset();
    @(negedge clk); #2 reset_n = 1'b1;
    @(negedge clk);
    idle(1'b0); idle(1'b0); idle(1'b0);
    chk("ar_mon_after", MonDReg, 32'd0);
    chk("ar_ready_after", monitor_ready, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      r = {$urandom(), $urandom()};
      jw = r[37:0];
      jw[17:14] = 4'b0;
      c = $urandom_range(0, 99);
      rq = 1'($urandom_range(0, 1));
      ld = 1'b0; wr = 1'b0; rd = 1'b0;
      if (busy == 0) begin
        if (c < 20) ld = 1'b1;
        else if (c < 45) wr = 1'b1;
        else if (c < 70) rd = 1'b1;
        else if (c < 75) begin wr = 1'b1; rd = 1'b1; end
        else if (c < 82) begin ld = 1'b1; rd = 1'b1; end
      end else begin
        if (c < 10) rd = 1'b1;
        else if (c < 18) wr = 1'b1;
      end
      step(ld, wr, rd, jw, rq);
    end
    for (int k = 0; k < 8; k++) idle(1'b0);

    chk("acc_left", acc_q.size(), 0);
    chk("done_left", done_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_jtag_ocimem_sequencer.md
CPU_JTAG_OCIMEM_SEQUENCER -- requirements
Module: cpu_jtag_ocimem_sequencer

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: jdo  input  38  JTAG debug data word, qualified by the strobes below.
REQ-004 SHALL have ports: take_action_ocimem_a  input  1  one-cycle strobe: load address.
REQ-005 SHALL have ports: take_action_ocimem_b  input  1  one-cycle strobe: write data.
REQ-006 SHALL have ports: take_no_action_ocimem_a  input  1  one-cycle strobe: read.
REQ-007 SHALL have ports: cpu_req  input  1  CPU request for the shared debug RAM.
REQ-008 SHALL have ports: cpu_gnt  output  1  CPU owns the RAM this cycle.
REQ-009 SHALL have ports: mem_cs, mem_we  output  1 each  JTAG-side RAM chip-select and write enable.
REQ-010 SHALL have ports: mem_addr  output  8  word address; mem_wdata  output  32  write data; mem_rdata  input  32  read data, valid one cycle after mem_cs.
REQ-011 SHALL have ports: MonDReg  output  32  captured read data; monitor_ready  output  1  last command done; monitor_error  output  1  command dropped.

Function
REQ-012 SHALL implement FSM IDLE, WAIT_GNT, ACCESS, CAPTURE.
REQ-013 Address load: in any state, take_action_ocimem_a SHALL set addr <= jdo[17:10], clear monitor_ready, and SHALL NOT access the RAM.
REQ-014 Write: take_action_ocimem_b in IDLE SHALL latch wdata <= jdo[34:3], op=write, then go to WAIT_GNT.
REQ-015 Read: take_no_action_ocimem_a in IDLE SHALL set op=read, then go to WAIT_GNT.
REQ-016 If both take_action_ocimem_b and take_no_action_ocimem_a are high in the same cycle, write SHALL win and the read SHALL be dropped with monitor_error=1.
REQ-017 A read/write strobe outside IDLE SHALL be dropped and SHALL set monitor_error=1; monitor_error SHALL clear on the next accepted command.
REQ-018 In WAIT_GNT, cpu_req low SHALL move to ACCESS; cpu_req high SHALL keep cpu_gnt=1 and increment a 2-bit starve counter.
REQ-019 When the starve counter reaches 3, JTAG SHALL win the next cycle regardless of cpu_req (cpu_gnt=0); counter SHALL clear on entering ACCESS.
REQ-020 cpu_gnt SHALL be 1 in IDLE and WAIT_GNT (subject to REQ-019) and 0 in ACCESS and CAPTURE.
REQ-021 ACCESS SHALL last exactly one cycle with mem_cs=1, mem_addr=addr, mem_we=(op==write), mem_wdata=wdata; mem_cs/mem_we SHALL be 0 in all other states.
REQ-022 Write in ACCESS SHALL return to IDLE and set monitor_ready=1 on the same edge; read SHALL go to CAPTURE.
REQ-023 CAPTURE SHALL load MonDReg <= mem_rdata, set monitor_ready=1, return to IDLE.
REQ-024 Latency with cpu_req low: write monitor_ready visible 2 cycles after strobe; read MonDReg/monitor_ready visible 3 cycles after strobe.
REQ-025 Address arithmetic SHALL be 8-bit modulo; 0xFF+1 wraps to 0x00.
REQ-026 monitor_ready SHALL clear when a read/write command is accepted.

Reset
REQ-027 reset_n low SHALL asynchronously force state=IDLE, addr=0, wdata=0, MonDReg=0, starve=0, monitor_ready=0, monitor_error=0, mem_cs=0, mem_we=0, cpu_gnt=1.
REQ-028 Reset during ACCESS/CAPTURE SHALL abort the access with no MonDReg update after release.

Configuration
REQ-029 With OCIMEM_AUTOINC_EN defined, addr SHALL increment by 1 at the end of every ACCESS (unless an address-load strobe occurs that cycle, which takes priority).
REQ-030 Without OCIMEM_AUTOINC_EN, addr SHALL change only on take_action_ocimem_a.

Verification
REQ-031 Load addr 0x10, write jdo[34:3]=0xDEADBEEF, cpu_req=0 -> mem_cs=mem_we=1, mem_addr=0x10 one cycle after strobe; monitor_ready=1 two cycles after.
REQ-032 RAM[0x10]=0xDEADBEEF, read at 0x10 -> MonDReg=0xDEADBEEF and monitor_ready=1 three cycles after strobe; with OCIMEM_AUTOINC_EN addr=0x11, without addr=0x10.
REQ-033 cpu_req held high, issue read -> cpu_gnt stays 1 for 3 cycles, then drops for 2 cycles (ACCESS, CAPTURE), then returns to 1.
REQ-034 Addr 0xFF, write with OCIMEM_AUTOINC_EN -> next write lands at 0x00.
REQ-035 Read strobe during CAPTURE, and simultaneous write+read in IDLE -> monitor_error=1, only one access issued, write data stored.
REQ-036 Assert reset_n=0 during ACCESS of a read -> all outputs at reset values immediately; MonDReg=0 after release.
